// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 8-slot TDM receive path.
package tdm_pkg;

  localparam int unsigned N_SLOTS = 8;
  localparam int unsigned SLOT_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

endpackage : tdm_pkg

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; decoder counterpart of the 8-to-1 selector.
module dec3to8
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]  i_sel,
  input  logic               i_en,
  output logic [N_SLOTS-1:0] o_we_c
);

  always_comb begin
    o_we_c = '0;
    if (i_en) begin
      o_we_c[i_sel] = 1'b1;
    end
  end

endmodule : dec3to8

// File: rtl/demux8_tdm_rx.sv
// Serial TDM receiver: distributes strobed bits into an 8-slot shadow register and
// publishes each complete frame as a registered word with a one-cycle valid pulse.
module demux8_tdm_rx
  import tdm_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sync,
  input  logic               din,
  output logic [SLOT_W-1:0]  S,
  output logic [N_SLOTS-1:0] F,
  output logic               valid,
  output logic               err
);

  localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(0);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(N_SLOTS - 1);

  tdm_state_t         r_state;
  logic [SLOT_W-1:0]  r_slot;
  logic [N_SLOTS-1:0] r_shadow;
  logic [N_SLOTS-1:0] r_f;
  logic               r_valid;
  logic               r_err;

  tdm_state_t         w_state_nxt;
  logic [SLOT_W-1:0]  w_slot_nxt;
  logic [N_SLOTS-1:0] w_shadow_nxt;
  logic [N_SLOTS-1:0] w_f_nxt;
  logic               w_valid_nxt;
  logic               w_err_nxt;
  logic [SLOT_W-1:0]  w_sel;
  logic               w_wr;
  logic [N_SLOTS-1:0] w_we;

  dec3to8 u_dec (
    .i_sel  (w_sel),
    .i_en   (w_wr),
    .o_we_c (w_we)
  );

  // State, slot counter, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_slot   <= SLOT_FIRST;
      r_shadow <= '0;
      r_f      <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_shadow <= w_shadow_nxt;
      r_f      <= w_f_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next-state: lock on sync, a sync seen mid-frame restarts the frame at slot 0.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_f_nxt     = r_f;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_sel       = r_slot;
    w_wr        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (en && sync) begin
          w_sel       = SLOT_FIRST;
          w_wr        = 1'b1;
          w_slot_nxt  = SLOT_W'(1);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (en) begin
          w_wr = 1'b1;
          if (sync && (r_slot != SLOT_FIRST)) begin
            w_err_nxt  = 1'b1;
            w_sel      = SLOT_FIRST;
            w_slot_nxt = SLOT_W'(1);
          end else begin
            w_slot_nxt = SLOT_W'(r_slot + SLOT_W'(1));
            if (r_slot == SLOT_LAST) begin
              w_f_nxt     = {din, r_shadow[N_SLOTS-2:0]};
              w_valid_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_shadow_nxt = (r_shadow & ~w_we) | (w_we & {N_SLOTS{din}});

  assign S     = r_slot;
  assign F     = r_f;
  assign valid = r_valid;
  assign err   = r_err;

endmodule : demux8_tdm_rx
